board_io_ctrl: RTL and testbench

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

---
 rtl/board_io_ctrl.sv | 156 +++++++++++++++
 tb/tb_board_io_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// Board I/O front end: synchronizes and debounces buttons and switches, raises sticky press
// interrupts, and drives blinking/blankable seven-segment digits.
module board_io_ctrl #(
  parameter int W_KEY        = 4,
  parameter int W_SW         = 18,
  parameter int N_HEX        = 8,
  parameter int DB_CYCLES    = 250000,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W_KEY-1:0]     key_n_i,
  input  logic [W_SW-1:0]      sw_i,
  output logic [W_KEY-1:0]     key_o,
  output logic [W_KEY-1:0]     key_press_o,
  output logic [W_KEY-1:0]     key_event_o,
  output logic                 irq_o,
  input  logic                 irq_clr_i,
  output logic [W_SW-1:0]      sw_o,
  input  logic [4*N_HEX-1:0]   hex_value_i,
  input  logic [N_HEX-1:0]     hex_en_i,
  input  logic [N_HEX-1:0]     hex_blink_i,
  output logic [7*N_HEX-1:0]   hex_o
);

  localparam int NB = W_KEY + W_SW;
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  // Raw idle pattern: buttons released (high), switches low.
  localparam logic [NB-1:0] IDLE_RAW   = {{W_SW{1'b0}}, {W_KEY{1'b1}}};

  logic [NB-1:0]    meta_r;
  logic [NB-1:0]    sync_r;
  logic [NB-1:0]    stable_r;
  logic [NB-1:0]    stable_next_s;
  logic [NB-1:0]    level_s;
  logic [CW-1:0]    cnt_r      [NB];
  logic [CW-1:0]    cnt_next_s [NB];
  logic [W_KEY-1:0] press_r;
  logic [W_KEY-1:0] event_r;
  logic             irq_r;
  logic [BW-1:0]    blink_cnt_r;
  logic             blink_phase_r;
  logic [7*N_HEX-1:0] hex_r;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // XOR with the idle pattern inverts the key bits so every level is active-high.
  assign level_s = sync_r ^ IDLE_RAW;

  always_comb begin
    stable_next_s = stable_r;
    for (int i = 0; i < NB; i++) begin
      cnt_next_s[i] = '0;
      if (level_s[i] != stable_r[i]) begin
        if (cnt_r[i] == DB_LAST) begin
          stable_next_s[i] = level_s[i];
          cnt_next_s[i]    = '0;
        end else begin
          cnt_next_s[i] = cnt_r[i] + CW'(1);
        end
      end else begin
        cnt_next_s[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r   <= IDLE_RAW;
      sync_r   <= IDLE_RAW;
      stable_r <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      meta_r   <= {sw_i, key_n_i};
      sync_r   <= meta_r;
      stable_r <= stable_next_s;
      for (int i = 0; i < NB; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
    end
  end

  // A press pulse is registered in the same edge as the debounced rise; a press wins over a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_r <= '0;
      event_r <= '0;
      irq_r   <= 1'b0;
    end else begin
      press_r <= stable_next_s[W_KEY-1:0] & ~stable_r[W_KEY-1:0];
      event_r <= (event_r & ~{W_KEY{irq_clr_i}}) | press_r;
      irq_r   <= |event_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (blink_cnt_r == BLINK_LAST) begin
      blink_cnt_r   <= '0;
      blink_phase_r <= ~blink_phase_r;
    end else begin
      blink_cnt_r   <= blink_cnt_r + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_r <= '1;
    end else begin
      for (int d = 0; d < N_HEX; d++) begin
        if (!hex_en_i[d] || (hex_blink_i[d] && blink_phase_r)) begin
          hex_r[7*d +: 7] <= 7'h7F;
        end else begin
          hex_r[7*d +: 7] <= seg_decode(hex_value_i[4*d +: 4]);
        end
      end
    end
  end

  assign key_o       = stable_r[W_KEY-1:0];
  assign sw_o        = stable_r[NB-1:W_KEY];
  assign key_press_o = press_r;
  assign key_event_o = event_r;
  assign irq_o       = irq_r;
  assign hex_o       = hex_r;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboard bench for board_io_ctrl with a short debounce window, short blink period and two digits.
module tb_board_io_ctrl;

  localparam int W_KEY = 4;
  localparam int W_SW  = 18;
  localparam int N_HEX = 2;

  logic clk = 1'b0;
  logic reset;
  logic [W_KEY-1:0]   key_n_i;
  logic [W_SW-1:0]    sw_i;
  logic [W_KEY-1:0]   key_o, key_press_o, key_event_o;
  logic               irq_o, irq_clr_i;
  logic [W_SW-1:0]    sw_o;
  logic [4*N_HEX-1:0] hex_value_i;
  logic [N_HEX-1:0]   hex_en_i, hex_blink_i;
  logic [7*N_HEX-1:0] hex_o;

  board_io_ctrl #(
    .W_KEY(W_KEY), .W_SW(W_SW), .N_HEX(N_HEX), .DB_CYCLES(4), .BLINK_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .key_n_i(key_n_i), .sw_i(sw_i),
    .key_o(key_o), .key_press_o(key_press_o), .key_event_o(key_event_o),
    .irq_o(irq_o), .irq_clr_i(irq_clr_i), .sw_o(sw_o),
    .hex_value_i(hex_value_i), .hex_en_i(hex_en_i), .hex_blink_i(hex_blink_i),
    .hex_o(hex_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   r_rel;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic string sel_name(input int s);
    case (s)
      0: return "key_o";
      1: return "key_press_o";
      2: return "key_event_o";
      3: return "irq_o";
      4: return "sw_o";
      5: return "hex_o";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int s);
    case (s)
      0: return 32'(key_o);
      1: return 32'(key_press_o);
      2: return 32'(key_event_o);
      3: return 32'(irq_o);
      4: return 32'(sw_o);
      5: return 32'(hex_o);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_at(input int dly, input int sel, input logic [31:0] exp);
    exp_t e;
    int   idx;
    e.due = cyc + dly;
    e.sel = sel;
    e.exp = exp;
    idx = sb.size();
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].due > e.due) begin
        idx = k;
        break;
      end
    end
    sb.insert(idx, e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check_val(sel_name(e.sel), observe(e.sel), e.exp);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      tick(1);
    end
    if (sb.size() != 0) begin
      check_val("scoreboard_drain", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    key_n_i     = '1;
    sw_i        = '0;
    sw_i[17]    = 1'b1;
    irq_clr_i   = 1'b0;
    hex_value_i = '0;
    hex_en_i    = '0;
    hex_blink_i = '0;
    tick(3);

    // Reset state
    expect_at(0, 0, 32'h0);
    expect_at(0, 1, 32'h0);
    expect_at(0, 2, 32'h0);
    expect_at(0, 3, 32'h0);
    expect_at(0, 4, 32'h0);
    expect_at(0, 5, 32'h3FFF);
    tick(1);

    // Switch held through reset release rises 6 cycles later
    reset = 1'b0;
    r_rel = cyc;
    for (int j = 1; j <= 5; j++) expect_at(j, 4, 32'h0);
    expect_at(6, 4, 32'h0002_0000);
    drain();
    tick(4);

    // 3-cycle glitch on key 1 must be filtered
    key_n_i[1] = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      expect_at(j, 0, 32'h0);
      expect_at(j, 1, 32'h0);
    end
    expect_at(10, 3, 32'h0);
    tick(3);
    key_n_i[1] = 1'b1;
    drain();

    // Clean press on key 0
    key_n_i[0] = 1'b0;
    expect_at(5, 0, 32'h0);
    expect_at(6, 0, 32'h1);
    expect_at(5, 1, 32'h0);
    expect_at(6, 1, 32'h1);
    expect_at(7, 1, 32'h0);
    expect_at(6, 2, 32'h0);
    expect_at(7, 2, 32'h1);
    expect_at(7, 3, 32'h0);
    expect_at(8, 3, 32'h1);
    drain();

    // Key 2 press coincident with a clear keeps only the new flag
    key_n_i[2] = 1'b0;
    expect_at(6, 1, 32'h4);
    tick(6);
    irq_clr_i = 1'b1;
    expect_at(1, 2, 32'h4);
    expect_at(1, 3, 32'h1);
    expect_at(2, 3, 32'h1);
    tick(1);
    irq_clr_i = 1'b0;
    drain();

    // Plain clear: flags drop, irq follows one cycle later
    irq_clr_i = 1'b1;
    expect_at(1, 2, 32'h0);
    expect_at(1, 3, 32'h1);
    expect_at(2, 3, 32'h0);
    tick(1);
    irq_clr_i = 1'b0;
    drain();

    // Release produces no pulse
    key_n_i = '1;
    expect_at(5, 0, 32'h5);
    expect_at(6, 0, 32'h0);
    expect_at(6, 1, 32'h0);
    expect_at(7, 1, 32'h0);
    expect_at(8, 2, 32'h0);
    drain();

    // Seven-segment decode, blanking and blink
    hex_value_i = 8'hA5;
    hex_en_i    = 2'b11;
    hex_blink_i = 2'b00;
    expect_at(1, 5, 32'h0412);
    tick(1);
    hex_en_i = 2'b01;
    expect_at(1, 5, 32'h3F92);
    tick(1);
    hex_en_i    = 2'b11;
    hex_blink_i = 2'b01;
    for (int j = 1; j <= 20; j++) begin
      int e;
      int ph;
      e  = cyc + j;
      ph = ((e - 1 - r_rel) / 8) % 2;
      expect_at(j, 5, {18'h0, 7'h08, (ph == 1) ? 7'h7F : 7'h12});
    end
    drain();

    // Reset mid-debounce aborts; a key held through release yields one press
    key_n_i[3] = 1'b0;
    tick(3);
    reset = 1'b1;
    expect_at(1, 0, 32'h0);
    expect_at(1, 1, 32'h0);
    expect_at(1, 2, 32'h0);
    expect_at(1, 4, 32'h0);
    expect_at(1, 5, 32'h3FFF);
    tick(2);
    reset = 1'b0;
    expect_at(5, 0, 32'h0);
    expect_at(6, 0, 32'h8);
    expect_at(5, 1, 32'h0);
    expect_at(6, 1, 32'h8);
    expect_at(7, 1, 32'h0);
    expect_at(7, 2, 32'h8);
    drain();

    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
